decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised RV32I instruction-decode pipeline stage. It sits between fetch and execute.
- Fully decodes all RV32I opcodes into register indices, a sign-extended immediate, an ALU op and control flags.
- Uses a valid/ready handshake on both sides. An optional skid buffer keeps full throughput under back-pressure.
- Adds flush support so branch redirects can squash in-flight decodes.

Parameters:
- PC_W, 32, width of the pc sideband carried alongside instr.
- SKID, 1, 1 = 2-entry skid buffer (in_ready is registered); 0 = single output register (in_ready = !out_valid || out_ready).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squashes all held and incoming entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  pc of the decoded instruction.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  32  sign-extended immediate.
- alu_op  out  alu_op_e  ALU operation, from the define.sv enum.
- reg_we  out  1  writes rd.
- mem_re, mem_we  out  1 each  load / store.
- mem_size  out  3  funct3 of load/store.
- is_branch, is_jump  out  1 each  B-type / JAL or JALR.
- use_pc  out  1  ALU operand A is pc (AUIPC, JAL).
- use_imm  out  1  ALU operand B is imm.
- illegal  out  1  present only with DECODER_ILLEGAL_EN.

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, in_ready=1, every payload output 0, skid entry emptied. Reset during back-pressure discards all entries with no output.
- Transfer occurs when valid&&ready on a side. Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N. One instruction per cycle is sustained while out_ready=1.
- Payload outputs hold stable while out_valid=1 and out_ready=0.
- SKID=1:
  - States are EMPTY, ONE and TWO.
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept with out_ready=0. In this case the new entry goes to the skid register and in_ready drops the next cycle.
  - TWO -> ONE on out_ready. The skid entry moves to the output and in_ready rises.
  - ONE -> EMPTY on out_ready with no accept.
  - ONE stays ONE on simultaneous accept and out_ready.
  - Order is strictly FIFO.
- SKID=0: in_ready is combinational as stated above. No skid register is generated.
- flush=1: the next state is EMPTY, out_valid=0 and in_ready=1. An input presented in the flush cycle is dropped. Flush has priority over accept and over out_ready. Reset has priority over flush.
- Decode, registered at acceptance time:
  - imm formats, sign-extended from instr[31]:
    - I: instr[31:20].
    - S: {instr[31:25], instr[11:7]}.
    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
    - U: {instr[31:12], 12'b0}.
    - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
    - R-type: imm=0.
  - rs1/rs2/rd are forced to 0 when the format does not use them. Examples: S/B give rd=0; U/J give rs1=rs2=0; I gives rs2=0.
  - OP and OPIMM: funct3 plus funct7[5] select the op.
    - funct7[5] distinguishes SUB from ADD and SRA/SRAI from SRL/SRLI.
    - For OPIMM it is honoured only for shifts; ADDI with instr[30]=1 is still ADD.
  - alu_op follows the ALU_<MNEMONIC> members of alu_op_e:
    - Branches map to ALU_BEQ..ALU_BGEU.
    - Loads, stores and JALR map to ALU_ADD.
    - LUI maps to ALU_LUI; AUIPC maps to ALU_AUIPC; JAL maps to ALU_ADD with use_pc=1.
  - reg_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP and OPIMM. reg_we=0 otherwise, and also whenever the rd field is 0.
  - FENCE and SYSTEM decode as NOPs: all enables 0, alu_op=ALU_ADD.
  - Unknown opcodes decode as NOPs.

Optional Feature:
- Macro: DECODER_ILLEGAL_EN.
- When defined, the illegal port exists. illegal=1 in any of these cases:
  - Unknown opcode.
  - Bad funct3 for LOAD (3, 6 or 7), STORE (>2) or BRANCH (2 or 3).
  - Nonzero funct7 other than 0x20 on SUB/SRA/SRAI.
  - instr[1:0]!=2'b11.
- Illegal entries still flow through the pipe as NOPs.
- When not defined, the port is absent and the same encodings silently decode as NOPs.

Test Plan:
- LUI: 0x123450B7, out_ready=1 -> one cycle later out_valid=1, rd=1, imm=0x12345000, alu_op=ALU_LUI, reg_we=1, rs1=0.
- BEQ: 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, alu_op=ALU_BEQ, is_branch=1, reg_we=0.
- SW: 0x00512423 (sw x5,8(x2)) -> rs1=2, rs2=5, imm=8, mem_we=1, mem_size=2, rd=0, reg_we=0.
- Back-pressure with SKID=1: two back-to-back instructions, out_ready=0 -> in_ready=0 after the second. Then out_ready=1 -> both emerge in order on consecutive cycles, payload stable while stalled.
- Flush in state TWO while a third in_valid is presented -> next cycle out_valid=0 and in_ready=1; none of the three instructions ever appears.
- 0x00000000 with DECODER_ILLEGAL_EN -> illegal=1 and all enables 0. Reset asserted mid-stall -> out_valid=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   flush             squash every held and incoming entry
//   in_valid/in_ready upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_pc            pc of the presented instruction
//   rs1, rs2, rd      register indices (0 when the format has no such field)
//   imm               sign-extended immediate
//   alu_op            decode_pkg::alu_op_e
//   reg_we, mem_re, mem_we, mem_size, is_branch, is_jump, use_pc, use_imm
//   illegal           only when DECODER_ILLEGAL_EN is defined
//
// Parameters
//   PC_W  width of the pc sideband
//   SKID  1: two-entry skid buffer with a registered in_ready
//         0: single output register, in_ready = !out_valid || out_ready
//
// Optional feature macro: DECODER_ILLEGAL_EN (adds the illegal output).
// Illegal encodings always decode as NOPs; the macro only exposes the flag.

package decode_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        is_branch;
    logic        is_jump;
    logic        use_pc;
    logic        use_imm;
`ifdef DECODER_ILLEGAL_EN
    logic        illegal;
`endif
  } dec_t;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output alu_op_e         alu_op,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic [2:0]      mem_size,
  output logic            is_branch,
  output logic            is_jump,
  output logic            use_pc,
  output logic            use_imm
`ifdef DECODER_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  // ---------------------------------------------------------------- decode
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        f7_ok;
  logic        legal;
  alu_op_e     arith_op;
  alu_op_e     br_op;
  dec_t        dec;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  // funct7 may only be 0x00 or 0x20 where bit 30 picks the op variant.
  assign f7_ok = (f7 == 7'h00) || (f7 == 7'h20);

  always_comb begin
    legal = 1'b1;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_FENCE, OPC_SYSTEM: legal = 1'b1;
      OPC_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3);
      OPC_LOAD:   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OPC_STORE:  legal = (f3 <= 3'd2);
      OPC_OPIMM:  legal = (f3 == 3'd5) ? f7_ok : 1'b1;
      OPC_OP:     legal = ((f3 == 3'd0) || (f3 == 3'd5)) ? f7_ok : 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  // Bit 30 selects SUB only for register-register ops; for OPIMM it
  // is part of the immediate except on right shifts.
  always_comb begin
    arith_op = ALU_ADD;
    case (f3)
      3'd0: arith_op = (opc == OPC_OP && in_instr[30]) ? ALU_SUB : ALU_ADD;
      3'd1: arith_op = ALU_SLL;
      3'd2: arith_op = ALU_SLT;
      3'd3: arith_op = ALU_SLTU;
      3'd4: arith_op = ALU_XOR;
      3'd5: arith_op = in_instr[30] ? ALU_SRA : ALU_SRL;
      3'd6: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    br_op = ALU_BEQ;
    case (f3)
      3'd1: br_op = ALU_BNE;
      3'd4: br_op = ALU_BLT;
      3'd5: br_op = ALU_BGE;
      3'd6: br_op = ALU_BLTU;
      3'd7: br_op = ALU_BGEU;
      default: br_op = ALU_BEQ;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.alu = ALU_ADD;
    if (legal) begin
      case (opc)
        OPC_LUI: begin
          dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.alu = ALU_LUI;
          dec.reg_we = 1'b1; dec.use_imm = 1'b1;
        end
        OPC_AUIPC: begin
          dec.rd = in_instr[11:7]; dec.imm = imm_u; dec.alu = ALU_AUIPC;
          dec.reg_we = 1'b1; dec.use_pc = 1'b1; dec.use_imm = 1'b1;
        end
        OPC_JAL: begin
          dec.rd = in_instr[11:7]; dec.imm = imm_j;
          dec.reg_we = 1'b1; dec.is_jump = 1'b1;
          dec.use_pc = 1'b1; dec.use_imm = 1'b1;
        end
        OPC_JALR: begin
          dec.rs1 = in_instr[19:15]; dec.rd = in_instr[11:7]; dec.imm = imm_i;
          dec.reg_we = 1'b1; dec.is_jump = 1'b1; dec.use_imm = 1'b1;
        end
        OPC_BRANCH: begin
          dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
          dec.imm = imm_b; dec.alu = br_op; dec.is_branch = 1'b1;
        end
        OPC_LOAD: begin
          dec.rs1 = in_instr[19:15]; dec.rd = in_instr[11:7]; dec.imm = imm_i;
          dec.reg_we = 1'b1; dec.mem_re = 1'b1; dec.mem_size = f3;
          dec.use_imm = 1'b1;
        end
        OPC_STORE: begin
          dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.imm = imm_s;
          dec.mem_we = 1'b1; dec.mem_size = f3; dec.use_imm = 1'b1;
        end
        OPC_OPIMM: begin
          dec.rs1 = in_instr[19:15]; dec.rd = in_instr[11:7]; dec.imm = imm_i;
          dec.alu = arith_op; dec.reg_we = 1'b1; dec.use_imm = 1'b1;
        end
        OPC_OP: begin
          dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
          dec.rd = in_instr[11:7]; dec.alu = arith_op; dec.reg_we = 1'b1;
        end
        default: ; // FENCE / SYSTEM: NOP
      endcase
    end
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
`ifdef DECODER_ILLEGAL_EN
    dec.illegal = !legal || (in_instr[1:0] != 2'b11);
`endif
  end

  // ------------------------------------------------------------- pipeline
  dec_t            out_q;
  logic [PC_W-1:0] out_pc_q;
  logic            accept;

  // A flush drops whatever is offered in the same cycle.
  assign accept = in_valid && in_ready && !flush;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  generate
    if (SKID != 0) begin : g_skid
      state_e          state, state_nx;
      dec_t            skid_q;
      logic [PC_W-1:0] skid_pc_q;
      logic            ready_q;
      logic            load_out, load_skid, move_skid;

      always_comb begin
        state_nx  = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
          state_nx = S_EMPTY;
        end else begin
          case (state)
            S_EMPTY: if (accept) begin
              load_out = 1'b1; state_nx = S_ONE;
            end
            S_ONE: begin
              if (accept && out_ready) begin
                load_out = 1'b1;
              end else if (accept) begin
                load_skid = 1'b1; state_nx = S_TWO;
              end else if (out_ready) begin
                state_nx = S_EMPTY;
              end
            end
            S_TWO: if (out_ready) begin
              move_skid = 1'b1; state_nx = S_ONE;
            end
            default: state_nx = S_EMPTY;
          endcase
        end
      end

      // in_ready comes straight from a flop so upstream sees no
      // combinational path from out_ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          state     <= S_EMPTY;
          ready_q   <= 1'b1;
          out_q     <= '0;
          out_pc_q  <= '0;
          skid_q    <= '0;
          skid_pc_q <= '0;
        end else begin
          state   <= state_nx;
          ready_q <= (state_nx != S_TWO);
          if (load_out) begin
            out_q    <= dec;
            out_pc_q <= in_pc;
          end else if (move_skid) begin
            out_q    <= skid_q;
            out_pc_q <= skid_pc_q;
          end
          if (load_skid) begin
            skid_q    <= dec;
            skid_pc_q <= in_pc;
          end
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = (state != S_EMPTY);
    end else begin : g_noskid
      logic vld_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q    <= 1'b0;
          out_q    <= '0;
          out_pc_q <= '0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (accept) begin
          vld_q    <= 1'b1;
          out_q    <= dec;
          out_pc_q <= in_pc;
        end else if (out_ready) begin
          vld_q <= 1'b0;
        end
      end

      assign in_ready  = !vld_q || out_ready;
      assign out_valid = vld_q;
    end
  endgenerate

  assign out_pc    = out_pc_q;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign alu_op    = out_q.alu;
  assign reg_we    = out_q.reg_we;
  assign mem_re    = out_q.mem_re;
  assign mem_we    = out_q.mem_we;
  assign mem_size  = out_q.mem_size;
  assign is_branch = out_q.is_branch;
  assign is_jump   = out_q.is_jump;
  assign use_pc    = out_q.use_pc;
  assign use_imm   = out_q.use_imm;
`ifdef DECODER_ILLEGAL_EN
  assign illegal   = out_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, hand-written handshake sequences and a
// randomized stream, all checked against a queue-based model of the stage.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  alu_op_e     alu_op;
  logic        reg_we, mem_re, mem_we, is_branch, is_jump, use_pc, use_imm;
  logic [2:0]  mem_size;
`ifdef DECODER_ILLEGAL_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
    .is_branch(is_branch), .is_jump(is_jump), .use_pc(use_pc), .use_imm(use_imm)
`ifdef DECODER_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    alu_op_e     alu;
    logic        reg_we, mem_re, mem_we;
    logic [2:0]  mem_size;
    logic        br, jmp, use_pc, use_imm;
    logic        ill;
    logic [31:0] pc;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    obs_t        exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  obs_t q[$];
  vec_t tab[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t mask(input obs_t o);
    obs_t r = o;
`ifndef DECODER_ILLEGAL_EN
    r.ill = 1'b0;
`endif
    return r;
  endfunction

  function automatic obs_t collect();
    obs_t o;
    o = '{rs1: rs1, rs2: rs2, rd: rd, imm: imm, alu: alu_op, reg_we: reg_we,
          mem_re: mem_re, mem_we: mem_we, mem_size: mem_size, br: is_branch,
          jmp: is_jump, use_pc: use_pc, use_imm: use_imm, ill: 1'b0, pc: out_pc};
`ifdef DECODER_ILLEGAL_EN
    o.ill = illegal;
`endif
    return o;
  endfunction

  // two's complement sign extension of an n-bit field
  function automatic logic [31:0] sext(input int v, input int n);
    return 32'((v ^ (1 << (n - 1))) - (1 << (n - 1)));
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic obs_t ref_dec(input logic [31:0] i);
    obs_t o = '0;
    logic legal = 1'b1;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    int fi = int'(i[31:20]);
    int fs = int'({i[31:25], i[11:7]});
    int fb = int'({i[31], i[7], i[30:25], i[11:8], 1'b0});
    int fj = int'({i[31], i[19:12], i[20], i[30:21], 1'b0});
    alu_op_e ar;
    case (f3)
      0: ar = (i[6:0] == 7'h33 && i[30]) ? ALU_SUB : ALU_ADD;
      1: ar = ALU_SLL;  2: ar = ALU_SLT; 3: ar = ALU_SLTU; 4: ar = ALU_XOR;
      5: ar = i[30] ? ALU_SRA : ALU_SRL; 6: ar = ALU_OR; default: ar = ALU_AND;
    endcase
    o.alu = ALU_ADD;
    case (i[6:0])
      7'h37: begin o.rd = i[11:7]; o.imm = {i[31:12], 12'h0}; o.alu = ALU_LUI;
                   o.reg_we = 1; o.use_imm = 1; end
      7'h17: begin o.rd = i[11:7]; o.imm = {i[31:12], 12'h0}; o.alu = ALU_AUIPC;
                   o.reg_we = 1; o.use_pc = 1; o.use_imm = 1; end
      7'h6F: begin o.rd = i[11:7]; o.imm = sext(fj, 21); o.reg_we = 1;
                   o.jmp = 1; o.use_pc = 1; o.use_imm = 1; end
      7'h67: begin o.rs1 = i[19:15]; o.rd = i[11:7]; o.imm = sext(fi, 12);
                   o.reg_we = 1; o.jmp = 1; o.use_imm = 1; end
      7'h63: begin
        legal = !(f3 == 2 || f3 == 3);
        o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.imm = sext(fb, 13); o.br = 1;
        case (f3)
          0: o.alu = ALU_BEQ;  1: o.alu = ALU_BNE;  4: o.alu = ALU_BLT;
          5: o.alu = ALU_BGE;  6: o.alu = ALU_BLTU; default: o.alu = ALU_BGEU;
        endcase
      end
      7'h03: begin
        legal = !(f3 == 3 || f3 >= 6);
        o.rs1 = i[19:15]; o.rd = i[11:7]; o.imm = sext(fi, 12);
        o.reg_we = 1; o.mem_re = 1; o.mem_size = f3; o.use_imm = 1;
      end
      7'h23: begin
        legal = (f3 <= 2);
        o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.imm = sext(fs, 12);
        o.mem_we = 1; o.mem_size = f3; o.use_imm = 1;
      end
      7'h13: begin
        if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
        o.rs1 = i[19:15]; o.rd = i[11:7]; o.imm = sext(fi, 12);
        o.alu = ar; o.reg_we = 1; o.use_imm = 1;
      end
      7'h33: begin
        if (f3 == 0 || f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
        o.rs1 = i[19:15]; o.rs2 = i[24:20]; o.rd = i[11:7];
        o.alu = ar; o.reg_we = 1;
      end
      7'h0F, 7'h73: ;
      default: legal = 0;
    endcase
    if (!legal) o = '0;
    if (o.rd == 0) o.reg_we = 0;
    o.ill = !legal || (i[1:0] != 2'b11);
    return o;
  endfunction

  // One clock: drive, advance the model (a FIFO of at most two entries),
  // then check handshake and payload.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
    obs_t e;
    logic acc;
    reset = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
        e = ref_dec(ins); e.pc = pc;
        q.push_back(mask(e));
      end
    end
    #1;
    check("in_ready", 128'(in_ready), 128'(q.size() < 2));
    check("out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) check("payload", 128'(collect()), 128'(q[0]));
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic [31:0] im, input alu_op_e op,
                              input logic [6:0] fl, input logic [2:0] sz, input logic il);
    vec_t v;
    v.instr = ins;
    v.exp = '{rs1: a, rs2: b, rd: d, imm: im, alu: op, reg_we: fl[6], mem_re: fl[5],
              mem_we: fl[4], mem_size: sz, br: fl[3], jmp: fl[2], use_pc: fl[1],
              use_imm: fl[0], ill: il, pc: 32'h0};
    return v;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i = $urandom;
    case ($urandom_range(0, 11))
      0: i[6:0] = 7'h37;  1: i[6:0] = 7'h17; 2: i[6:0] = 7'h6F; 3: i[6:0] = 7'h67;
      4: i[6:0] = 7'h63;  5: i[6:0] = 7'h03; 6: i[6:0] = 7'h23; 7: i[6:0] = 7'h13;
      8: i[6:0] = 7'h33;  9: i[6:0] = 7'h0F; 10: i[6:0] = 7'h73;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return i;
  endfunction

  initial begin
    obs_t snap, e;
    int   pcn;
    // flags: {reg_we, mem_re, mem_we, br, jmp, use_pc, use_imm}
    tab.push_back(mk(32'h123450B7, 0, 0, 1, 32'h12345000, ALU_LUI,   7'b1000001, 0, 0));
    tab.push_back(mk(32'hFE208EE3, 1, 2, 0, 32'hFFFFFFFC, ALU_BEQ,   7'b0001000, 0, 0));
    tab.push_back(mk(32'h00512423, 2, 5, 0, 32'h00000008, ALU_ADD,   7'b0010001, 2, 0));
    tab.push_back(mk(32'hFFF20193, 4, 0, 3, 32'hFFFFFFFF, ALU_ADD,   7'b1000001, 0, 0));
    tab.push_back(mk(32'h40335293, 6, 0, 5, 32'h00000403, ALU_SRA,   7'b1000001, 0, 0));
    tab.push_back(mk(32'h409403B3, 8, 9, 7, 32'h00000000, ALU_SUB,   7'b1000000, 0, 0));
    tab.push_back(mk(32'h010000EF, 0, 0, 1, 32'h00000010, ALU_ADD,   7'b1000111, 0, 0));
    tab.push_back(mk(32'h00008067, 1, 0, 0, 32'h00000000, ALU_ADD,   7'b0000101, 0, 0));
    tab.push_back(mk(32'hFFC5A503, 11, 0, 10, 32'hFFFFFFFC, ALU_ADD, 7'b1100001, 2, 0));
    tab.push_back(mk(32'h0FF0000F, 0, 0, 0, 32'h00000000, ALU_ADD,   7'b0000000, 0, 0));
    tab.push_back(mk(32'h00000000, 0, 0, 0, 32'h00000000, ALU_ADD,   7'b0000000, 0, 1));
    tab.push_back(mk(32'h00000073, 0, 0, 0, 32'h00000000, ALU_ADD,   7'b0000000, 0, 0));
    tab.push_back(mk(32'hFFFFF117, 0, 0, 2, 32'hFFFFF000, ALU_AUIPC, 7'b1000011, 0, 0));
    tab.push_back(mk(32'h0000B083, 0, 0, 0, 32'h00000000, ALU_ADD,   7'b0000000, 0, 1));
    tab.push_back(mk(32'h00419463, 3, 4, 0, 32'h00000008, ALU_BNE,   7'b0001000, 0, 0));
    tab.push_back(mk(32'h021050B3, 0, 0, 0, 32'h00000000, ALU_ADD,   7'b0000000, 0, 1));

    // reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_payload", 128'(collect()), 128'(obs_t'('0)));

    // table vectors, streamed back to back
    for (int k = 0; k < tab.size(); k++) begin
      cyc(0, 0, 1, tab[k].instr, 32'h1000 + 32'(k * 4), 1);
      e = tab[k].exp; e.pc = 32'h1000 + 32'(k * 4);
      check("vec", 128'(collect()), 128'(mask(e)));
    end
    cyc(0, 0, 0, 0, 0, 1);

    // back-pressure: two in, stall, then drain in order
    cyc(0, 0, 1, 32'h123450B7, 32'h200, 0);
    snap = collect();
    cyc(0, 0, 1, 32'hFE208EE3, 32'h204, 0);
    check("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
    cyc(0, 0, 1, 32'h00512423, 32'h208, 0);
    check("bp_stable", 128'(collect()), 128'(snap));
    cyc(0, 0, 0, 0, 0, 1);
    check("bp_second_pc", 128'(out_pc), 128'(32'h204));
    check("bp_in_ready_high", 128'(in_ready), 128'(1'b1));
    cyc(0, 0, 0, 0, 0, 1);
    check("bp_drained", 128'(out_valid), 128'(1'b0));

    // flush in TWO with a third instruction offered
    cyc(0, 0, 1, 32'h00000013, 32'h300, 0);
    cyc(0, 0, 1, 32'h00100093, 32'h304, 0);
    cyc(0, 1, 1, 32'h00200113, 32'h308, 0);
    check("flush_valid", 128'(out_valid), 128'(1'b0));
    check("flush_ready", 128'(in_ready), 128'(1'b1));
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      check("flush_quiet", 128'(out_valid), 128'(1'b0));
    end

    // reset in the middle of a stall
    cyc(0, 0, 1, 32'h409403B3, 32'h400, 0);
    cyc(0, 0, 1, 32'h010000EF, 32'h404, 0);
    cyc(1, 0, 1, 32'h00419463, 32'h408, 0);
    check("rst_stall_valid", 128'(out_valid), 128'(1'b0));
    check("rst_stall_payload", 128'(collect()), 128'(obs_t'('0)));
    cyc(0, 0, 0, 0, 0, 1);

    // randomized stream
    pcn = 0;
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0), rnd_instr(), 32'(pcn * 4),
          ($urandom_range(0, 2) != 0));
      pcn++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
